// File: rtl/cache_victim_wbuf_pkg.sv
// Shared types and geometry helpers for the victim writeback buffer and the cache bus FSM.
package cache_victim_wbuf_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } drain_state_t;

    function automatic int beats_of(input int line_len, input int beat_len);
        return line_len / beat_len;
    endfunction

    function automatic int beat_bits_of(input int line_len, input int beat_len);
        return $clog2(line_len / beat_len);
    endfunction

    function automatic int line_off_of(input int line_len);
        return $clog2(line_len / 8);
    endfunction

    function automatic int byte_off_of(input int beat_len);
        return $clog2(beat_len / 8);
    endfunction

endpackage

// File: rtl/cache_victim_match.sv
// Line-granular tag comparator across all buffer entries; only valid entries can hit.
module cache_victim_match #(
    parameter int NUMENTRIES = 2,
    parameter int TAGW       = 50
) (
    input  logic [NUMENTRIES-1:0] valid,
    input  logic [TAGW-1:0]       tags [NUMENTRIES],
    input  logic [TAGW-1:0]       lookup_tag,
    output logic                  hit
);

    logic [NUMENTRIES-1:0] match;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUMENTRIES; i++) begin
            match[i] = valid[i] && (tags[i] == lookup_tag);
        end
    end

    assign hit = |match;

endmodule

// File: rtl/cache_victim_wbuf.sv
// Dirty-victim writeback buffer: queues evicted lines and drains them as in-order beat bursts.
module cache_victim_wbuf
    import cache_victim_wbuf_pkg::*;
#(
    parameter int NUMENTRIES = 2,
    parameter int LINELEN    = 512,
    parameter int BEATLEN    = 64,
    parameter int PA_BITS    = 56
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               VictimValid,
    output logic               VictimReady,
    input  logic [PA_BITS-1:0] VictimAdr,
    input  logic [LINELEN-1:0] VictimLine,
    output logic               BusReq,
    input  logic               BusAck,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [BEATLEN-1:0] BusWData,
    output logic               BusLast,
    input  logic [PA_BITS-1:0] LookupAdr,
    output logic               LookupHit,
    output logic               Empty
);

    localparam int BEATS    = beats_of(LINELEN, BEATLEN);
    localparam int BEATBITS = beat_bits_of(LINELEN, BEATLEN);
    localparam int LINEOFF  = line_off_of(LINELEN);
    localparam int BYTEOFF  = byte_off_of(BEATLEN);
    localparam int PTRW     = $clog2(NUMENTRIES);
    localparam int CNTW     = PTRW + 1;
    localparam int TAGW     = PA_BITS - LINEOFF;

    logic [NUMENTRIES-1:0] valid;
    logic [TAGW-1:0]       tag_mem  [NUMENTRIES];
    logic [LINELEN-1:0]    data_mem [NUMENTRIES];
    logic [PTRW-1:0]       head, tail;
    logic [CNTW-1:0]       count, count_next;
    logic [BEATBITS-1:0]   beat_cnt;
    drain_state_t          state, state_next;
    logic                  full, push, pop, last_beat;
    logic                  unused_offsets;

    // Handshakes: a push happens on VictimValid & VictimReady at the edge; a beat
    // is transferred on BusReq & BusAck, and BusReq/BusAdr/BusWData hold until then.
    assign full        = (count == CNTW'(NUMENTRIES));
    assign VictimReady = ~full;
    assign push        = VictimValid & VictimReady;
    assign last_beat   = (beat_cnt == BEATBITS'(BEATS - 1));
    assign BusReq      = (state == BURST);
    assign BusLast     = BusReq & last_beat;
    assign pop         = BusReq & BusAck & last_beat;
    assign Empty       = (count == '0);
    assign BusAdr      = {tag_mem[head], beat_cnt, {BYTEOFF{1'b0}}};
    assign BusWData    = data_mem[head][int'(beat_cnt) * BEATLEN +: BEATLEN];

    assign unused_offsets = ^{VictimAdr[LINEOFF-1:0], LookupAdr[LINEOFF-1:0]};

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Staying in BURST after a pop when anything is left gives back-to-back lines.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = BURST;
            BURST:   if (pop && count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            beat_cnt <= '0;
            state    <= IDLE;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (BusReq && BusAck) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    // Line storage is deliberately not reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[tail]  <= VictimAdr[PA_BITS-1:LINEOFF];
            data_mem[tail] <= VictimLine;
        end
    end

    cache_victim_match #(
        .NUMENTRIES (NUMENTRIES),
        .TAGW       (TAGW)
    ) u_match (
        .valid      (valid),
        .tags       (tag_mem),
        .lookup_tag (LookupAdr[PA_BITS-1:LINEOFF]),
        .hit        (LookupHit)
    );

    ack_only_with_req: assert property (@(posedge clk) disable iff (!reset) BusAck |-> BusReq);
    push_never_when_full: assert property (@(posedge clk) disable iff (!reset) push |-> (count < CNTW'(NUMENTRIES)));

endmodule

// File: doc/cache_victim_wbuf.md
Name: cache_victim_wbuf

Overview:
- Writeback-side counterpart to victim selection. Once the replacement logic has chosen a dirty victim line, the cache pushes that evicted line into this buffer and immediately reuses the way.
- The buffer drains queued lines to the bus as beat-sized write bursts, in FIFO order.
- It exposes an address-match output so the cache stalls a miss refill of a line that is still queued, preventing a stale read.

Parameters:
- NUMENTRIES, 2: number of whole-line entries; a power of 2, at least 2.
- LINELEN, 512: cache line width in bits.
- BEATLEN, 64: bus data width in bits; must divide LINELEN.
- PA_BITS, 56: physical address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset; the block is reset while reset=0.
- VictimValid  in  1  cache offers an evicted dirty line.
- VictimReady  out  1  buffer can accept a line this cycle.
- VictimAdr  in  PA_BITS  byte address of the line; offset bits are ignored.
- VictimLine  in  LINELEN  line data; beat 0 is bits [BEATLEN-1:0].
- BusReq  out  1  write beat valid.
- BusAck  in  1  bus accepted the current beat.
- BusAdr  out  PA_BITS  byte address of the current beat.
- BusWData  out  BEATLEN  current beat data.
- BusLast  out  1  current beat is the final beat of its line.
- LookupAdr  in  PA_BITS  address being missed on by the cache.
- LookupHit  out  1  a queued or draining line matches LookupAdr at line granularity.
- Empty  out  1  no entries are valid; the cache uses this as flush-complete.

Behaviour:
- Derived constants:
  - BEATS = LINELEN/BEATLEN.
  - BEATBITS = $clog2(BEATS).
  - LINEOFF = $clog2(LINELEN/8).
  - BYTEOFF = $clog2(BEATLEN/8).
- Storage:
  - Circular FIFO with per-entry valid bit, line tag VictimAdr[PA_BITS-1:LINEOFF], and line data.
  - Head and tail pointers are $clog2(NUMENTRIES) bits and wrap modulo NUMENTRIES.
  - An occupancy counter of $clog2(NUMENTRIES)+1 bits distinguishes full from empty.
- Push:
  - VictimReady = ~Full, registered from the current state and never dependent on BusAck.
  - A push occurs when VictimValid & VictimReady. The entry is written at tail on the clock edge, and tail and count advance.
  - When full, a pop in the same cycle does not allow a push in that cycle.
- Drain FSM, states IDLE and BURST:
  - IDLE: BusReq=0. Enter BURST on the next edge when count>0, including an entry pushed in the previous cycle. Beat counter is 0.
  - BURST: BusReq=1.
    - BusWData = head line beat [BeatCnt]. BusAdr = {head tag, BeatCnt, BYTEOFF zeros}. BusLast = (BeatCnt==BEATS-1).
    - BusAck with not-last: BeatCnt+1.
    - BusAck with last: pop head (valid cleared, head+1, count-1) and BeatCnt returns to 0.
      - If the post-pop count is greater than 0, counting any same-cycle push, remain in BURST and start the next line with no bubble.
      - Otherwise go to IDLE.
  - BusReq, BusAdr and BusWData hold steady until BusAck.
  - Beats of a line are never reordered or interleaved with another line.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Lookup:
  - LookupHit is combinational: OR over valid entries of (tag == LookupAdr[PA_BITS-1:LINEOFF]).
  - The head entry is compared until its last beat is acked; the entry stops matching the cycle after the pop.
  - A same-cycle push is not visible to the match until the next cycle.
- Empty = (count==0).
- Reset (reset=0, asynchronous):
  - All valid bits, head, tail, count and BeatCnt go to 0; FSM goes to IDLE.
  - Outputs: BusReq=0, BusLast=0, LookupHit=0, Empty=1, VictimReady=1.
  - BusAdr and BusWData are don't-care while BusReq=0.
  - Reset mid-burst drops the line with no partial completion. Data RAM contents are not cleared.
- Assertions:
  - BusAck only while BusReq.
  - No push when VictimReady=0.

Decomposition:
- Cache package holds:
  - the enum typedef for the drain states (IDLE, BURST);
  - helper localparam functions for BEATS, BEATBITS, LINEOFF and BYTEOFF, shared with the cache bus FSM.
- One sub-module, cache_victim_match: NUMENTRIES-way tag comparator with valid masking, producing LookupHit.
- The FIFO and FSM stay in the top module.

Test Plan:
- Bench parameters: LINELEN=256, BEATLEN=64, NUMENTRIES=2, PA_BITS=32. This gives 4 beats, LINEOFF=5, BYTEOFF=3.
- Single line, BusAck held 1:
  - Stimulus: push Adr 0x1000_0040, data beats 0xA0..0xA3.
  - Required: one cycle later BusReq=1. BusAdr is 0x40, 0x48, 0x50, 0x58 on consecutive cycles. BusLast only on 0x58. Empty=1 the cycle after the final ack.
- Back-pressure:
  - Stimulus: BusAck=0 for 3 cycles on beat 2.
  - Required: BusAdr=0x...50 and BusWData stable for those cycles; beat 3 follows the ack.
- Full and ordering:
  - Stimulus: push lines 0x100 and 0x200 while BusAck=0.
  - Required: VictimReady=0 and a third push is blocked. On the ack after the line 0x100 last beat, VictimReady=1 the next cycle. Line 0x200 starts with no idle cycle, and lines drain in order.
- Lookup:
  - Stimulus: queue 0x300; set LookupAdr=0x31C.
  - Required: LookupHit=1 until the line 0x300 final ack; 0 the cycle after. LookupAdr=0x320 returns LookupHit=0.
- Simultaneous push/pop:
  - Stimulus: count=1, a push coincides with the last-beat ack.
  - Required: count stays 1, BURST continues, and the new line's beat 0 follows.
- Reset mid-burst:
  - Stimulus: reset=0 asynchronously between edges during beat 1.
  - Required: BusReq falls immediately, Empty=1, VictimReady=1. After release, no beat is issued until a new push.
